// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
//
// Handshake: start acts as the valid strobe and ~busy as ready. An op is taken
// only on an edge where start=1, cancel=0, busy=0 and op is a recognised code;
// start while busy is dropped, never queued. busy is registered, so the edge on
// which it falls is still a not-ready edge. hi/lo are plain register read ports.
interface mult_div_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, cancel, input busy, hi, lo);
    modport slave  (input start, op, A, B, cancel, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage.
// The result is computed combinationally at issue, parked in a pending register
// and committed to HI/LO after MULT_CYCLES or DIV_CYCLES edges, so the visible
// latency is fixed while HI/LO hold their old contents during RUN.
// Optional feature macro MDU_MADD_EN enables ops 7..10 (MADD/MADDU/MSUB/MSUBU),
// which accumulate into {hi,lo} at completion; undefined, those codes are NOPs.
// dbg_state exposes the FSM state (0 IDLE, 1 RUN).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    mult_div_unit_if.slave     bus,
    output logic               dbg_state
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic [1:0] {ACC_SET = 2'd0, ACC_ADD = 2'd1, ACC_SUB = 2'd2} acc_t;

    localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

    state_t      state;
    logic [4:0]  counter;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] pend_val;
    acc_t        pend_mode;

    // Arithmetic on the live operands; only latched when an op issues.
    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic [31:0] a_mag, b_mag, uq, ur, sq, sr;
    logic [63:0] div_s, div_u;

    // Operand datapath: signed/unsigned products and quotient/remainder pairs.
    always_comb begin
        a_sx   = {{32{bus.A[31]}}, bus.A};
        b_sx   = {{32{bus.B[31]}}, bus.B};
        prod_s = a_sx * b_sx;
        prod_u = {32'h0, bus.A} * {32'h0, bus.B};
        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000.
        a_mag  = bus.A[31] ? -bus.A : bus.A;
        b_mag  = bus.B[31] ? -bus.B : bus.B;
        uq     = '0;
        ur     = '0;
        if (bus.B != 32'h0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        sq     = (bus.A[31] ^ bus.B[31]) ? -uq : uq;
        sr     = bus.A[31] ? -ur : ur;
        div_s  = {sr, sq};
        div_u  = {32'h0, 32'h0};
        if (bus.B != 32'h0) begin
            div_u = {bus.A % bus.B, bus.A / bus.B};
        end
        // Divide by zero is not trapped: quotient all ones, remainder = dividend.
        if (bus.B == 32'h0) begin
            div_s = {bus.A, 32'hFFFF_FFFF};
            div_u = {bus.A, 32'hFFFF_FFFF};
        end
    end

    logic        op_valid;
    logic        op_is_mt;
    logic [4:0]  issue_last;
    logic [63:0] issue_val;
    acc_t        issue_mode;
    logic        issue;

    // Op decode: which codes are live, their latency and how they commit.
    always_comb begin
        op_valid   = 1'b0;
        op_is_mt   = 1'b0;
        issue_last = MULT_LAST;
        issue_val  = prod_s;
        issue_mode = ACC_SET;
        case (bus.op)
            4'd1: begin op_valid = 1'b1; issue_val = prod_s; end
            4'd2: begin op_valid = 1'b1; issue_val = prod_u; end
            4'd3: begin op_valid = 1'b1; issue_val = div_s; issue_last = DIV_LAST; end
            4'd4: begin op_valid = 1'b1; issue_val = div_u; issue_last = DIV_LAST; end
            4'd5, 4'd6: begin op_valid = 1'b1; op_is_mt = 1'b1; end
`ifdef MDU_MADD_EN
            4'd7:  begin op_valid = 1'b1; issue_val = prod_s; issue_mode = ACC_ADD; end
            4'd8:  begin op_valid = 1'b1; issue_val = prod_u; issue_mode = ACC_ADD; end
            4'd9:  begin op_valid = 1'b1; issue_val = prod_s; issue_mode = ACC_SUB; end
            4'd10: begin op_valid = 1'b1; issue_val = prod_u; issue_mode = ACC_SUB; end
`endif
            default: ;
        endcase
        issue = bus.start & ~bus.cancel & ~busy_q & op_valid & (state == IDLE);
    end

    // Control FSM: issue, count down, commit pending result to HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            counter   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_val  <= '0;
            pend_mode <= ACC_SET;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (op_is_mt) begin
                            if (bus.op == 4'd5) hi_q <= bus.A;
                            else                lo_q <= bus.A;
                        end else begin
                            state     <= RUN;
                            busy_q    <= 1'b1;
                            counter   <= issue_last;
                            pend_val  <= issue_val;
                            pend_mode <= issue_mode;
                        end
                    end
                end
                RUN: begin
                    if (counter == 5'd0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        case (pend_mode)
                            ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + pend_val;
                            ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - pend_val;
                            default: {hi_q, lo_q} <= pend_val;
                        endcase
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases then random ops,
// compared against an arithmetic model of HI/LO kept in the bench.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    logic dbg_state;

    mult_div_unit_if bus();

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_md(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6);
    endfunction

    // Reference: new {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, ps, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ps = 64'(sa * sb);
        pu = ua * ub;
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd7:  return acc + ps;
            4'd8:  return acc + pu;
            4'd9:  return acc - ps;
            4'd10: return acc - pu;
            default: return acc;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: one-cycle start pulse, then follow the op to completion.
    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic cxl, input string tag);
        int n, cnt;
        logic [63:0] e;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.A      = a;
        bus.B      = b;
        bus.cancel = cxl;
        tick();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.A      = $urandom();
        bus.B      = $urandom();
        if (cxl || !(is_md(op) || is_mt(op))) begin
            check({tag, "_nobusy"}, 64'(bus.busy), 64'd0);
            check({tag, "_hilo_kept"}, {bus.hi, bus.lo}, {m_hi, m_lo});
        end else if (is_mt(op)) begin
            if (op == 4'd5) m_hi = a;
            else            m_lo = a;
            check({tag, "_nobusy"}, 64'(bus.busy), 64'd0);
            check({tag, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
        end else begin
            exp_q.push_back(md_model(op, a, b, {m_hi, m_lo}));
            n   = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
            cnt = 0;
            while (bus.busy === 1'b1 && cnt < 64) begin
                cnt++;
                check({tag, "_hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
                tick();
            end
            check({tag, "_latency"}, 64'(cnt), 64'(n));
            e = exp_q.pop_front();
            check({tag, "_result"}, {bus.hi, bus.lo}, e);
            {m_hi, m_lo} = e;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Main sequence
    initial begin
        int cnt;
        logic [63:0] e;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.A      = '0;
        bus.B      = '0;
        bus.cancel = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

        drive_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
        check("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        drive_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
        check("multu_const", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);
        drive_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        check("div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        drive_op(4'd4, 32'd7, 32'd0, 1'b0, "divu0");
        check("divu0_const", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
        drive_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        drive_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, "mthi");
        drive_op(4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, "mtlo");
        check("mt_const", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        // start during busy must be ignored
        bus.start = 1'b1; bus.op = 4'd3; bus.A = 32'hFFFF_FF9C; bus.B = 32'd7;
        exp_q.push_back(md_model(4'd3, 32'hFFFF_FF9C, 32'd7, {m_hi, m_lo}));
        tick();
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 64) begin
            cnt++;
            bus.start = (cnt == 3);
            bus.op    = 4'd1;
            bus.A     = 32'd11;
            bus.B     = 32'd13;
            tick();
        end
        bus.start = 1'b0;
        check("ignore_latency", 64'(cnt), 64'(DIV_N));
        e = exp_q.pop_front();
        check("ignore_result", {bus.hi, bus.lo}, e);
        {m_hi, m_lo} = e;
        tick();
        check("ignore_no_second", 64'(bus.busy), 64'd0);

        // reset in the middle of a divide
        bus.start = 1'b1; bus.op = 4'd4; bus.A = 32'd1000; bus.B = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (DIV_N + 3) tick();
        check("midreset_late_busy", 64'(bus.busy), 64'd0);
        check("midreset_late_hilo", {bus.hi, bus.lo}, 64'd0);

        // cancel suppresses both multi-cycle and move ops
        drive_op(4'd1, 32'd9, 32'd9, 1'b1, "cancel_mult");
        drive_op(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, "cancel_mtlo");
        drive_op(4'd1, 32'd6, 32'd7, 1'b0, "mult_b2b");
        drive_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_b2b");

        // accumulate carry across LO into HI
        drive_op(4'd5, 32'h0, 32'd0, 1'b0, "madd_prep_hi");
        drive_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_prep_lo");
        drive_op(4'd8, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MDU_MADD_EN
        check("maddu_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
`else
        check("maddu_const", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        // random ops, codes 0..15 with occasional cancel and idle gaps
        for (int i = 0; i < 80; i++) begin
            drive_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                     ($urandom_range(0, 7) == 0), "rand");
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
